// File: rtl/mul_div_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with start/done handshake and flush.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [2:0]        op_reg;
  logic              sign_a;
  logic              sign_b;
  // Multiply: operand = |multiplicand|, acc = {high partial, multiplier}.
  // Divide:   operand = |divisor|,      acc low half = dividend shifting into quotient.
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   result_reg;

  // Accept-cycle decode
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_result;

  assign is_div   = func3[2];
  assign a_signed = (func3 == 3'b001) || (func3 == 3'b010) || (is_div && !func3[0]);
  assign b_signed = (func3 == 3'b001) || (is_div && !func3[0]);
  assign a_neg    = a_signed && opA[XLEN-1];
  assign b_neg    = b_signed && opB[XLEN-1];
  assign mag_a    = a_neg ? -opA : opA;
  assign mag_b    = b_neg ? -opB : opB;
  assign div_zero = is_div && (opB == '0);
  assign div_ovf  = is_div && !func3[0] && (opA == {1'b1, {(XLEN-1){1'b0}}}) && (&opB);

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = func3[1] ? opA : '1;
    else if (div_ovf)
      special_result = func3[1] ? '0 : opA;
  end

  // One iteration of each datapath
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic              fits;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;

  assign add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
  assign mul_next = {add_sum, acc[XLEN-1:1]};
  assign shifted  = {rem, acc[XLEN-1]};
  assign diff     = shifted - {1'b0, operand};
  assign fits     = !diff[XLEN];
  assign rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_next = {acc[XLEN-2:0], fits};

  // Sign correction applied on the final iteration
  logic              negate;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_result;

  assign negate   = sign_a ^ sign_b;
  assign prod_fix = negate ? -mul_next : mul_next;
  assign quo_fix  = negate ? -quo_next : quo_next;
  assign rem_fix  = sign_a ? -rem_next : rem_next;

  always_comb begin
    final_result = prod_fix[2*XLEN-1:XLEN];
    if (op_reg[2])
      final_result = op_reg[1] ? rem_fix : quo_fix;
    else if (op_reg[1:0] == 2'b00)
      final_result = prod_fix[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      op_reg     <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      operand    <= '0;
      acc        <= '0;
      rem        <= '0;
      result_reg <= '0;
    end else if (flush && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_reg  <= func3;
            sign_a  <= a_neg;
            sign_b  <= b_neg;
            count   <= CW'(XLEN-1);
            operand <= is_div ? mag_b : mag_a;
            acc     <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            rem     <= '0;
            if (div_zero || div_ovf) begin
              result_reg <= special_result;
              state      <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (op_reg[2]) begin
            acc[XLEN-1:0] <= quo_next;
            rem           <= rem_next;
          end else begin
            acc <= mul_next;
          end
          if (count == '0) begin
            result_reg <= final_result;
            state      <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready  = (state == IDLE);
  assign busy   = (state == BUSY);
  assign done   = (state == DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed checks of mul_div_unit at XLEN=32 and XLEN=8: results, latency,
// busy window, reset mid-operation and flush behaviour.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start32 = 1'b0, flush32 = 1'b0;
  logic [2:0]  func3_32 = '0;
  logic [31:0] opA32 = '0, opB32 = '0, result32;
  logic        ready32, busy32, done32;

  logic        start8 = 1'b0, flush8 = 1'b0;
  logic [2:0]  func3_8 = '0;
  logic [7:0]  opA8 = '0, opB8 = '0, result8;
  logic        ready8, busy8, done8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .flush(flush32), .func3(func3_32),
    .opA(opA32), .opB(opB32), .ready(ready32), .busy(busy32), .done(done32),
    .result(result32)
  );

  mul_div_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .flush(flush8), .func3(func3_8),
    .opA(opA8), .opB(opB8), .ready(ready8), .busy(busy8), .done(done8),
    .result(result8)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    bit          w8;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  // Starts one op on the selected DUT and waits (bounded) for done.
  task automatic run_op(input bit w8, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    if (w8) begin
      start8 = 1'b1; func3_8 = f; opA8 = a[7:0]; opB8 = b[7:0];
    end else begin
      start32 = 1'b1; func3_32 = f; opA32 = a; opB32 = b;
    end
    @(posedge clk);
    #1;
    start8 = 1'b0; start32 = 1'b0;
    opA8 = 8'($urandom); opB8 = 8'($urandom);
    opA32 = $urandom; opB32 = $urandom;
    lat = -1; busy_cnt = 0; r = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (w8 ? done8 : done32) begin
        lat = c;
        r = w8 ? {24'd0, result8} : result32;
        break;
      end
      if (w8 ? busy8 : busy32) busy_cnt++;
    end
  endtask

  task automatic watch_no_done(input string tag);
    int pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done32) pulses++;
    end
    check(tag, 64'(pulses), 64'd0);
  endtask

  initial begin
    logic [31:0] r;
    int lat, bc;
    logic [31:0] prev;

    // 32-bit vectors
    vecs.push_back('{1'b0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33});
    vecs.push_back('{1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
    vecs.push_back('{1'b0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
    vecs.push_back('{1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back('{1'b0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33});
    vecs.push_back('{1'b0, 3'b011, 32'h80000000, 32'h00000002, 32'h00000001, 33});
    vecs.push_back('{1'b0, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
    vecs.push_back('{1'b0, 3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
    vecs.push_back('{1'b0, 3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33});
    vecs.push_back('{1'b0, 3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 33});
    vecs.push_back('{1'b0, 3'b101, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{1'b0, 3'b111, 32'h12345678, 32'h00000000, 32'h12345678, 1});
    vecs.push_back('{1'b0, 3'b110, 32'h12345678, 32'h00000000, 32'h12345678, 1});
    vecs.push_back('{1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    // 8-bit vectors
    vecs.push_back('{1'b1, 3'b000, 32'h0C, 32'h0D, 32'h9C, 9});
    vecs.push_back('{1'b1, 3'b001, 32'h80, 32'h80, 32'h40, 9});
    vecs.push_back('{1'b1, 3'b010, 32'hFF, 32'hFF, 32'hFF, 9});
    vecs.push_back('{1'b1, 3'b011, 32'hFF, 32'hFF, 32'hFE, 9});
    vecs.push_back('{1'b1, 3'b100, 32'h80, 32'h03, 32'hD6, 9});
    vecs.push_back('{1'b1, 3'b110, 32'h80, 32'h03, 32'hFE, 9});
    vecs.push_back('{1'b1, 3'b101, 32'hC8, 32'h07, 32'h1C, 9});
    vecs.push_back('{1'b1, 3'b111, 32'hC8, 32'h07, 32'h04, 9});
    vecs.push_back('{1'b1, 3'b100, 32'h07, 32'hFD, 32'hFE, 9});
    vecs.push_back('{1'b1, 3'b110, 32'h07, 32'hFD, 32'h01, 9});
    vecs.push_back('{1'b1, 3'b100, 32'h80, 32'hFF, 32'h80, 1});

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 64'(ready32), 64'd1);
    check("reset_busy", 64'(busy32), 64'd0);
    check("reset_done", 64'(done32), 64'd0);
    check("reset_result", 64'(result32), 64'd0);

    prev = '0;
    foreach (vecs[i]) begin
      run_op(vecs[i].w8, vecs[i].f, vecs[i].a, vecs[i].b, r, lat, bc);
      $display("op %0d w%0d func3=%b a=%h b=%h result=%h lat=%0d busy=%0d",
               i, vecs[i].w8 ? 8 : 32, vecs[i].f, vecs[i].a, vecs[i].b, r, lat, bc);
      check($sformatf("result_%0d", i), 64'(r), 64'(vecs[i].exp));
      check($sformatf("latency_%0d", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("busy_cycles_%0d", i), 64'(bc), 64'(vecs[i].lat - 1));
      if (!vecs[i].w8) prev = vecs[i].exp;
    end

    // Flush in cycle 10 of a DIV
    @(negedge clk);
    start32 = 1'b1; func3_32 = 3'b100; opA32 = 32'd100; opB32 = 32'd7;
    @(posedge clk);
    #1 start32 = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    check("flush_busy_before", 64'(busy32), 64'd1);
    flush32 = 1'b1;
    @(posedge clk);
    #1 flush32 = 1'b0;
    @(negedge clk);
    check("flush_ready", 64'(ready32), 64'd1);
    check("flush_busy", 64'(busy32), 64'd0);
    watch_no_done("flush_no_done");
    check("flush_result_held", 64'(result32), 64'(prev));
    $display("flush mid-DIV result=%h", result32);

    // start and flush together in IDLE
    @(negedge clk);
    start32 = 1'b1; flush32 = 1'b1; func3_32 = 3'b000; opA32 = 32'd5; opB32 = 32'd6;
    @(posedge clk);
    #1 begin start32 = 1'b0; flush32 = 1'b0; end
    @(negedge clk);
    check("startflush_busy", 64'(busy32), 64'd0);
    check("startflush_ready", 64'(ready32), 64'd1);
    watch_no_done("startflush_no_done");
    $display("start+flush in IDLE result=%h", result32);

    // Reset in cycle 5 of a MUL
    @(negedge clk);
    start32 = 1'b1; func3_32 = 3'b000; opA32 = 32'd9; opB32 = 32'd9;
    @(posedge clk);
    #1 start32 = 1'b0;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midreset_ready", 64'(ready32), 64'd1);
    check("midreset_busy", 64'(busy32), 64'd0);
    check("midreset_done", 64'(done32), 64'd0);
    check("midreset_result", 64'(result32), 64'd0);
    run_op(1'b0, 3'b000, 32'd3, 32'd4, r, lat, bc);
    $display("post-reset MUL 3x4 result=%h lat=%0d", r, lat);
    check("postreset_mul", 64'(r), 64'd12);
    check("postreset_lat", 64'(lat), 64'd33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
